// File: rtl/glyph_pkg.sv
// glyph_pkg: shared constants and types for the glyph memory loader.
//   GLYPH_BITS  - glyph word width
//   GLYPH_BYTES - payload bytes per frame (ceil(GLYPH_BITS/8))
//   CNT_W       - payload counter width
//   state_e     - loader FSM states
package glyph_pkg;

  localparam int unsigned GLYPH_BITS = 100;

  // Bytes needed to carry a word of the given width, MSB byte padded.
  function automatic int unsigned bytes_for(input int unsigned bits);
    return (bits + 32'd7) / 32'd8;
  endfunction

  localparam int unsigned GLYPH_BYTES = bytes_for(GLYPH_BITS);
  localparam int unsigned CNT_W       = $clog2(GLYPH_BYTES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    SKIP    = 2'd2,
    WRITE   = 2'd3
  } state_e;

endpackage : glyph_pkg

// File: rtl/glyph_loader_if.sv
// glyph_loader_if: byte-stream input and glyph-memory write port of the loader.
//   in_valid/in_data/in_ready - framed byte stream (valid/ready)
//   wr_en/wr_addr/wr_data     - glyph memory write port
//   done/err                  - single-cycle frame status pulses
//   busy                      - frame in progress
// Modports: master = byte source / memory side, slave = loader.
interface glyph_loader_if #(
  parameter int unsigned GLYPH_BITS = glyph_pkg::GLYPH_BITS
);

  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  wr_en;
  logic [7:0]            wr_addr;
  logic [GLYPH_BITS-1:0] wr_data;
  logic                  done;
  logic                  err;
  logic                  busy;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, done, err, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, done, err, busy
  );

endinterface : glyph_loader_if

// File: rtl/glyph_loader.sv
// glyph_loader: assembles framed bytes (index + ceil(GLYPH_BITS/8) payload
// bytes, MSB first) into one glyph word and writes it to the glyph memory.
// Frames with an index >= MEM_WIDTH are consumed and dropped with an err pulse.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - glyph_loader_if.slave: byte stream in, memory write port and
//         done/err/busy status out
// All outputs come straight from registers; nothing on the input side reaches
// an output combinationally.
module glyph_loader #(
  parameter int unsigned MEM_WIDTH  = 10,
  parameter int unsigned GLYPH_BITS = glyph_pkg::GLYPH_BITS
) (
  input  logic           clk,
  input  logic           rst,
  glyph_loader_if.slave  bus
);

  import glyph_pkg::*;

  localparam int unsigned NBYTES = bytes_for(GLYPH_BITS);
  localparam int unsigned CW     = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);

  state_e                state_q;
  logic                  in_ready_q;
  logic                  wr_en_q;
  logic                  done_q;
  logic                  err_q;
  logic                  busy_q;
  logic [7:0]            wr_addr_q;
  logic [GLYPH_BITS-1:0] sr_q;
  logic [GLYPH_BITS-1:0] sr_d;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;

  logic xfer;
  logic idx_ok;
  logic last_byte;

  // Byte handshake and frame decode helpers.
  assign xfer      = bus.in_valid && in_ready_q;
  assign idx_ok    = 32'(bus.in_data) < MEM_WIDTH;
  assign last_byte = (cnt_q == LAST_CNT);

  // MSB-first shift; the padding bits of the first byte fall off the top.
  assign sr_d  = {sr_q[GLYPH_BITS-9:0], bus.in_data};
  assign cnt_d = cnt_q + CW'(1);

  // Loader FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b1;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      wr_addr_q  <= '0;
      sr_q       <= '0;
      cnt_q      <= '0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (xfer) begin
            wr_addr_q <= bus.in_data;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= idx_ok ? PAYLOAD : SKIP;
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            sr_q <= sr_d;
            if (last_byte) begin
              cnt_q      <= '0;
              state_q    <= WRITE;
              in_ready_q <= 1'b0;
              wr_en_q    <= 1'b1;
              done_q     <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        SKIP: begin
          // Drain the payload of a bad-index frame without touching sr.
          if (xfer) begin
            if (last_byte) begin
              cnt_q   <= '0;
              state_q <= IDLE;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        WRITE: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = sr_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;

endmodule : glyph_loader

// File: tb/tb_glyph_loader.sv
// tb_glyph_loader: self-checking bench for glyph_loader with a behavioural
// glyph memory and a frame-level reference model.
module tb_glyph_loader;

  localparam int unsigned MEMW = 10;
  localparam int unsigned GB   = 100;
  localparam int unsigned NB   = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  glyph_loader_if #(.GLYPH_BITS(GB)) bus ();

  glyph_loader #(.MEM_WIDTH(MEMW), .GLYPH_BITS(GB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Glyph memory: write on the edge wr_en is sampled, registered read.
  logic [GB-1:0] mem [MEMW];
  logic [7:0]    rd_addr = 8'd0;
  logic [GB-1:0] data_o;
  always @(posedge clk) begin
    if (bus.wr_en && bus.wr_addr < 8'(MEMW)) mem[int'(bus.wr_addr)] <= bus.wr_data;
    data_o <= mem[int'(rd_addr)];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]    addr;
    logic [GB-1:0] data;
    logic          done;
    int            cyc;
  } wr_t;

  wr_t  wq[$];
  int   errq[$];
  logic err_rdy[$];
  int   rdylow[$];
  int   done_only = 0;

  // Observation log sampled mid-cycle.
  always @(negedge clk) begin
    wr_t w;
    if (!rst) begin
      if (bus.wr_en) begin
        w.addr = bus.wr_addr; w.data = bus.wr_data; w.done = bus.done; w.cyc = cyc;
        wq.push_back(w);
      end
      if (bus.done && !bus.wr_en) done_only++;
      if (bus.err) begin
        errq.push_back(cyc);
        err_rdy.push_back(bus.in_ready);
      end
      if (!bus.in_ready) rdylow.push_back(cyc);
    end
  end

  int checks = 0;
  int passed = 0;
  logic [7:0] pay [NB];

  task automatic clear_obs();
    wq.delete(); errq.delete(); err_rdy.delete(); rdylow.delete(); done_only = 0;
  endtask

  // Reference: payload as a big-endian number, reduced to the glyph width.
  function automatic logic [GB-1:0] model_word();
    logic [NB*8-1:0] acc;
    acc = '0;
    for (int i = 0; i < int'(NB); i++) acc = acc * 256 + (NB*8)'(pay[i]);
    return acc[GB-1:0];
  endfunction

  task automatic rand_payload();
    for (int i = 0; i < int'(NB); i++) pay[i] = 8'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, output int xcyc);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) begin
      checks++;
      $display("FAIL send_byte_timeout in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    xcyc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] idx, input bit throttle,
                            output int first_cyc, output int last_cyc);
    int c;
    send_byte(idx, first_cyc);
    for (int i = 0; i < int'(NB); i++) begin
      if (throttle) begin @(posedge clk); #1; end
      send_byte(pay[i], c);
    end
    last_cyc = c;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); else passed++;
    checks++; if (bus.wr_en !== 1'b0) $display("FAIL rst_wr_en got=%b exp=0", bus.wr_en); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL rst_done got=%b exp=0", bus.done); else passed++;
    checks++; if (bus.err !== 1'b0) $display("FAIL rst_err got=%b exp=0", bus.err); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", bus.busy); else passed++;
    checks++; if (bus.wr_addr !== 8'd0) $display("FAIL rst_wr_addr got=%0d exp=0", bus.wr_addr); else passed++;
    checks++; if (bus.wr_data !== '0) $display("FAIL rst_wr_data got=%h exp=0", bus.wr_data); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL post_rst_idle in_ready=%b busy=%b exp 1/0", bus.in_ready, bus.busy); else passed++;
  endtask

  task automatic test_basic();
    int f, l;
    logic [GB-1:0] exp;
    pay[0] = 8'hFF;
    for (int i = 1; i < 12; i++) pay[i] = 8'h00;
    pay[12] = 8'h01;
    exp = model_word();
    clear_obs();
    send_frame(8'd1, 1'b0, f, l);
    settle();
    checks++; if (wq.size() != 1) $display("FAIL basic_writes got=%0d exp=1", wq.size()); else passed++;
    if (wq.size() >= 1) begin
      checks++; if (wq[0].addr !== 8'd1) $display("FAIL basic_addr got=%0d exp=1", wq[0].addr); else passed++;
      checks++; if (wq[0].data !== exp) $display("FAIL basic_data got=%h exp=%h", wq[0].data, exp); else passed++;
      checks++; if (wq[0].done !== 1'b1) $display("FAIL basic_done got=%b exp=1", wq[0].done); else passed++;
      checks++; if (wq[0].cyc != l) $display("FAIL basic_wr_cycle got=%0d exp=%0d", wq[0].cyc, l); else passed++;
    end
    checks++; if (errq.size() != 0 || done_only != 0)
      $display("FAIL basic_no_err err=%0d stray_done=%0d exp 0/0", errq.size(), done_only); else passed++;
  endtask

  task automatic test_bad_index();
    int f, l;
    rand_payload();
    clear_obs();
    send_frame(8'(MEMW), 1'b0, f, l);
    settle();
    checks++; if (wq.size() != 0) $display("FAIL bad_no_write got=%0d exp=0", wq.size()); else passed++;
    checks++; if (errq.size() != 1) $display("FAIL bad_err_pulses got=%0d exp=1", errq.size()); else passed++;
    if (errq.size() >= 1) begin
      checks++; if (errq[0] != l) $display("FAIL bad_err_cycle got=%0d exp=%0d", errq[0], l); else passed++;
      checks++; if (err_rdy[0] !== 1'b1) $display("FAIL bad_err_ready got=%b exp=1", err_rdy[0]); else passed++;
    end
    checks++; if (bus.busy !== 1'b0) $display("FAIL bad_busy_after got=%b exp=0", bus.busy); else passed++;
    checks++; if (bus.wr_addr !== 8'(MEMW)) $display("FAIL bad_addr_latched got=%0d exp=%0d", bus.wr_addr, MEMW); else passed++;
  endtask

  task automatic test_back_to_back();
    int f1, l1, f2, l2;
    logic [7:0] a1, a2;
    logic [GB-1:0] e1, e2;
    a1 = 8'($urandom_range(0, MEMW-1));
    a2 = 8'($urandom_range(0, MEMW-1));
    clear_obs();
    rand_payload(); e1 = model_word();
    send_frame(a1, 1'b0, f1, l1);
    rand_payload(); e2 = model_word();
    send_frame(a2, 1'b0, f2, l2);
    settle();
    checks++; if (f2 - f1 != 15) $display("FAIL b2b_index_gap got=%0d exp=15", f2 - f1); else passed++;
    checks++; if (rdylow.size() != 2) $display("FAIL b2b_ready_low_cycles got=%0d exp=2", rdylow.size());
      else if (rdylow[0] != l1 || rdylow[1] != l2)
        $display("FAIL b2b_ready_low_at got=%0d,%0d exp=%0d,%0d", rdylow[0], rdylow[1], l1, l2);
      else passed++;
    checks++; if (wq.size() != 2) $display("FAIL b2b_writes got=%0d exp=2", wq.size()); else passed++;
    if (wq.size() == 2) begin
      checks++; if (wq[0].addr !== a1 || wq[0].data !== e1)
        $display("FAIL b2b_wr0 got=%0d/%h exp=%0d/%h", wq[0].addr, wq[0].data, a1, e1); else passed++;
      checks++; if (wq[1].addr !== a2 || wq[1].data !== e2)
        $display("FAIL b2b_wr1 got=%0d/%h exp=%0d/%h", wq[1].addr, wq[1].data, a2, e2); else passed++;
    end
  endtask

  task automatic test_throttled();
    int f, l;
    logic [GB-1:0] exp;
    pay[0] = 8'hFF;
    for (int i = 1; i < 12; i++) pay[i] = 8'h00;
    pay[12] = 8'h01;
    exp = model_word();
    clear_obs();
    send_frame(8'd1, 1'b1, f, l);
    settle();
    checks++; if (wq.size() != 1) $display("FAIL thr_writes got=%0d exp=1", wq.size()); else passed++;
    if (wq.size() >= 1) begin
      checks++; if (wq[0].data !== exp) $display("FAIL thr_data got=%h exp=%h", wq[0].data, exp); else passed++;
      checks++; if (wq[0].cyc != l) $display("FAIL thr_wr_cycle got=%0d exp=%0d", wq[0].cyc, l); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int c, f, l;
    logic [GB-1:0] exp;
    for (int i = 0; i < int'(NB); i++) pay[i] = 8'($urandom) | 8'h01;
    clear_obs();
    send_byte(8'd3, c);
    for (int i = 0; i < 6; i++) send_byte(pay[i], c);
    checks++; if (bus.busy !== 1'b1) $display("FAIL mid_busy got=%b exp=1", bus.busy); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.wr_en !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0)
      $display("FAIL mid_rst_ctrl got busy=%b rdy=%b wr=%b done=%b err=%b exp 0/1/0/0/0",
               bus.busy, bus.in_ready, bus.wr_en, bus.done, bus.err); else passed++;
    checks++; if (bus.wr_addr !== 8'd0 || bus.wr_data !== '0)
      $display("FAIL mid_rst_regs got addr=%0d data=%h exp 0/0", bus.wr_addr, bus.wr_data); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rand_payload(); exp = model_word();
    send_frame(8'd0, 1'b0, f, l);
    settle();
    checks++; if (wq.size() != 1) $display("FAIL mid_writes got=%0d exp=1", wq.size()); else passed++;
    if (wq.size() >= 1) begin
      checks++; if (wq[0].addr !== 8'd0 || wq[0].data !== exp)
        $display("FAIL mid_wr got=%0d/%h exp=0/%h", wq[0].addr, wq[0].data, exp); else passed++;
    end
  endtask

  task automatic test_random();
    int f, l, nerr;
    logic [7:0] idx;
    wr_t exp_q[$];
    wr_t w;
    nerr = 0;
    clear_obs();
    for (int k = 0; k < 8; k++) begin
      idx = 8'($urandom_range(0, 14));
      rand_payload();
      if (idx < 8'(MEMW)) begin
        w.addr = idx; w.data = model_word(); w.done = 1'b1; w.cyc = 0;
        exp_q.push_back(w);
      end else nerr++;
      send_frame(idx, 1'($urandom_range(0, 1)), f, l);
    end
    settle();
    checks++; if (wq.size() != exp_q.size()) $display("FAIL rnd_writes got=%0d exp=%0d", wq.size(), exp_q.size()); else passed++;
    checks++; if (errq.size() != nerr) $display("FAIL rnd_errs got=%0d exp=%0d", errq.size(), nerr); else passed++;
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      checks++; if (wq[i].addr !== exp_q[i].addr || wq[i].data !== exp_q[i].data)
        $display("FAIL rnd_wr%0d got=%0d/%h exp=%0d/%h", i, wq[i].addr, wq[i].data, exp_q[i].addr, exp_q[i].data);
      else passed++;
    end
  endtask

  task automatic test_loopback();
    int f, l;
    logic [GB-1:0] exp;
    rand_payload(); exp = model_word();
    send_frame(8'd0, 1'b0, f, l);
    settle();
    rd_addr = 8'd0;
    @(posedge clk); #1;
    checks++; if (data_o !== exp) $display("FAIL loopback got=%h exp=%h", data_o, exp); else passed++;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_bad_index();
    test_back_to_back();
    test_throttled();
    test_reset_mid();
    test_random();
    test_loopback();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_glyph_loader
